// File: rtl/led_blink_ctrl.sv
// Purpose: turns a one-cycle start request into blink_num on/off LED phases, each HALF_PERIOD clocks long, then pulses done.
// Latency: the first edge after an accepted start drives led_out high; done comes 2*HALF_PERIOD*blink_num cycles after that edge.
// Backpressure: start is dropped while busy; abort cancels the run with no done pulse, and abort beats a start in the same cycle.
module led_blink_ctrl #(
  parameter int unsigned HALF_PERIOD = 25000000,
  parameter int unsigned CNT_W       = 25,
  parameter int unsigned NUM_W       = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [NUM_W-1:0] blink_num,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             led_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  // Last count of a phase. Phases count 0..HALF_PERIOD-1, so HALF_PERIOD=1 ends a phase every cycle.
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(HALF_PERIOD - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             led_q, led_d;

  // Next-state logic. Every output is a flop, and each next value is decided together with the transition that causes it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    led_d   = led_q;

    unique case (state_q)
      IDLE: begin
        // Abort in IDLE has no effect of its own, but it still swallows a start in the same cycle.
        if (start && !abort) begin
          if (blink_num != '0) begin
            rem_d   = blink_num;
            cnt_d   = '0;
            state_d = ON;
            busy_d  = 1'b1;
            led_d   = 1'b1;
          end else begin
            // A zero-count request completes at once and never lights the LED.
            done_d = 1'b1;
          end
        end
      end

      ON: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          rem_d   = '0;
          busy_d  = 1'b0;
          led_d   = 1'b0;
        end else if (cnt_q == CNT_TERM) begin
          cnt_d   = '0;
          state_d = OFF;
          led_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      OFF: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          rem_d   = '0;
          busy_d  = 1'b0;
          led_d   = 1'b0;
        end else if (cnt_q == CNT_TERM) begin
          cnt_d = '0;
          rem_d = rem_q - NUM_W'(1);
          if (rem_q > NUM_W'(1)) begin
            state_d = ON;
            led_d   = 1'b1;
          end else begin
            // The last off-phase has ended. busy drops in the same cycle done rises, so a new start can be taken at once.
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        rem_d   = '0;
        busy_d  = 1'b0;
        led_d   = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset clears them at once, so a run cut short by reset ends without a done pulse.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      led_q   <= led_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign led_out = led_q;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Purpose: directed checks of led_blink_ctrl with HALF_PERIOD=4 (reset, blink runs, zero count, start while busy, back-to-back, abort, reset mid-run).
// Latency: outputs are sampled 1 ns after each rising edge; k counts edges after the edge that accepted start.
// Backpressure: none; the bench drives start/abort directly and every wait is a fixed number of cycles.
module tb_led_blink_ctrl;

  localparam int HP = 4;

  logic       sys_clk;
  logic       sys_rst;
  logic       start;
  logic [3:0] blink_num;
  logic       abort;
  logic       busy;
  logic       done;
  logic       led_out;

  int total;
  int bad;

  led_blink_ctrl #(
    .HALF_PERIOD(HP),
    .CNT_W      (3),
    .NUM_W      (4)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .start    (start),
    .blink_num(blink_num),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .led_out  (led_out)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Expected outputs k edges after the accepting edge of an n-blink run that nothing interrupts.
  function automatic int exp_led(input int n, input int k);
    return (k < 2 * HP * n && ((k / HP) % 2) == 0) ? 1 : 0;
  endfunction

  function automatic int exp_busy(input int n, input int k);
    return (k < 2 * HP * n) ? 1 : 0;
  endfunction

  function automatic int exp_done(input int n, input int k);
    return (k == 2 * HP * n) ? 1 : 0;
  endfunction

  // Call right after the accepting edge (k=0). Checks samples k=0..last_k and can pulse start (with inj_num) at sample inj_k.
  // Returns the number of rising edges seen on led_out, counting the first one at k=0.
  task automatic run_check(input string tag, input int n, input int last_k,
                           input int inj_k, input int inj_num, output int rises);
    int prev_led;
    prev_led = 0;
    rises    = 0;
    for (int k = 0; k <= last_k; k++) begin
      check($sformatf("%s_led_k%0d", tag, k),  int'(led_out), exp_led(n, k));
      check($sformatf("%s_busy_k%0d", tag, k), int'(busy),    exp_busy(n, k));
      check($sformatf("%s_done_k%0d", tag, k), int'(done),    exp_done(n, k));
      if (prev_led == 0 && led_out == 1'b1) rises++;
      prev_led = int'(led_out);
      if (k == inj_k) begin
        start     = 1'b1;
        blink_num = 4'(inj_num);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  // Pulse start for one edge. The bench is left at sample k=0 of the new run.
  task automatic fire(input int n);
    start     = 1'b1;
    blink_num = 4'(n);
    tick();
    start = 1'b0;
  endtask

  // Checks that the block stays idle with no done pulse for a number of cycles.
  task automatic expect_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check($sformatf("%s_led_%0d", tag, i),  int'(led_out), 0);
      check($sformatf("%s_busy_%0d", tag, i), int'(busy),    0);
      check($sformatf("%s_done_%0d", tag, i), int'(done),    0);
      tick();
    end
  endtask

  initial begin
    int rises;
    total     = 0;
    bad       = 0;
    start     = 1'b0;
    blink_num = 4'd0;
    abort     = 1'b0;

    // Reset asserted between edges. The outputs must clear before any clock edge arrives.
    sys_rst = 1'b0;
    #2;
    sys_rst = 1'b1;
    #1;
    check("rst_led",  int'(led_out), 0);
    check("rst_busy", int'(busy),    0);
    check("rst_done", int'(done),    0);
    repeat (3) tick();
    #2;
    sys_rst = 1'b0;
    tick();
    expect_idle("post_rst", 2);

    // Single blink: 4 high, 4 low, done at k=8.
    fire(1);
    run_check("one", 1, 9, -1, 0, rises);
    check("one_rises", rises, 1);

    // Three blinks: done at k=24 and exactly three rising edges.
    fire(3);
    run_check("three", 3, 25, -1, 0, rises);
    check("three_rises", rises, 3);

    // Zero count: done for one cycle only, LED and busy stay low.
    fire(0);
    check("zero_done", int'(done),    1);
    check("zero_busy", int'(busy),    0);
    check("zero_led",  int'(led_out), 0);
    tick();
    expect_idle("zero_after", 3);

    // A start asking for 5 blinks arrives mid-run. The run still has 2 blinks and finishes at k=16.
    fire(2);
    run_check("ign", 2, 17, 3, 5, rises);
    check("ign_rises", rises, 2);
    expect_idle("ign_after", 3);

    // Back-to-back: a start in the done cycle begins the next run with no idle gap.
    fire(1);
    run_check("b2b_a", 1, 8, 8, 1, rises);
    run_check("b2b_b", 1, 9, -1, 0, rises);
    check("b2b_b_rises", rises, 1);

    // Abort in the 2nd cycle of the first OFF phase of a 3-blink run.
    fire(3);
    run_check("abt", 3, 4, -1, 0, rises);
    check("abt_k5_led",  int'(led_out), 0);
    check("abt_k5_busy", int'(busy),    1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expect_idle("abt_after", 24);

    // Abort and start in the same IDLE cycle: nothing starts.
    start     = 1'b1;
    abort     = 1'b1;
    blink_num = 4'd2;
    tick();
    start = 1'b0;
    abort = 1'b0;
    expect_idle("abt_start", 5);

    // Reset in the ON phase: led_out drops before the next edge, and no done follows.
    fire(2);
    tick();
    tick();
    check("rston_led_before", int'(led_out), 1);
    #2;
    sys_rst = 1'b1;
    #1;
    check("rston_led",  int'(led_out), 0);
    check("rston_busy", int'(busy),    0);
    check("rston_done", int'(done),    0);
    repeat (3) tick();
    #2;
    sys_rst = 1'b0;
    tick();
    expect_idle("rston_after", 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
